// File: rtl/csr_unit_pkg.sv
// CSR address map, field positions, write masks and reset values shared by the CSR unit.
package csr_unit_pkg;

  localparam logic [13:0] CsrCrmd   = 14'h000;
  localparam logic [13:0] CsrPrmd   = 14'h001;
  localparam logic [13:0] CsrEcfg   = 14'h004;
  localparam logic [13:0] CsrEstat  = 14'h005;
  localparam logic [13:0] CsrEra    = 14'h006;
  localparam logic [13:0] CsrBadv   = 14'h007;
  localparam logic [13:0] CsrEentry = 14'h00C;
  localparam logic [13:0] CsrSave0  = 14'h030;
  localparam logic [13:0] CsrSave1  = 14'h031;
  localparam logic [13:0] CsrSave2  = 14'h032;
  localparam logic [13:0] CsrSave3  = 14'h033;
  localparam logic [13:0] CsrTid    = 14'h040;
  localparam logic [13:0] CsrTcfg   = 14'h041;
  localparam logic [13:0] CsrTval   = 14'h042;
  localparam logic [13:0] CsrTiclr  = 14'h044;
  localparam logic [13:0] CsrLlbctl = 14'h060;

  localparam int unsigned EcodeW     = 6;
  localparam int unsigned EsubcodeW  = 9;
  localparam int unsigned LieW       = 13;

  localparam int unsigned CrmdIeBit     = 2;
  localparam int unsigned EstatHwLsb    = 2;
  localparam int unsigned EstatTiBit    = 11;
  localparam int unsigned EstatIpiBit   = 12;
  localparam int unsigned EstatEcodeLsb = 16;
  localparam int unsigned EstatEsubLsb  = 22;
  localparam int unsigned TcfgEnBit     = 0;
  localparam int unsigned TcfgPerBit    = 1;
  localparam int unsigned LlbWcllbBit   = 1;
  localparam int unsigned LlbKloBit     = 2;

  localparam logic [31:0] CrmdRst     = 32'h0000_0008;
  localparam logic [31:0] CrmdWmask   = 32'h0000_01FF;
  localparam logic [31:0] PrmdWmask   = 32'h0000_0007;
  localparam logic [31:0] EcfgWmask   = 32'h0000_1BFF;
  localparam logic [31:0] EstatWmask  = 32'h0000_0003;
  localparam logic [31:0] EentryWmask = 32'hFFFF_FFC0;

  function automatic logic [31:0] wmerge(input logic [31:0] old_val, input logic [31:0] new_val,
                                         input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/csr_unit_if.sv
// Write-back <-> CSR unit request/response bundle, plus front-end targets and interrupt lines.
interface csr_unit_if;
  logic [13:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic [1:0]  cpu_level_o;
  logic        csr_we_i;
  logic [13:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic        llbit_we_i;
  logic        llbit_wdata_i;
  logic        excep_en_i;
  logic [5:0]  excep_ecode_i;
  logic [8:0]  excep_esubcode_i;
  logic [31:0] excep_pc_i;
  logic        excep_badv_we_i;
  logic [31:0] excep_badv_wdata_i;
  logic        ertn_en_i;
  logic [7:0]  hw_int_i;
  logic        ipi_i;
  logic        interrupt_o;
  logic [31:0] eentry_o;
  logic [31:0] era_o;
  logic        llbit_o;

  modport slave (
    input  csr_raddr_i, csr_we_i, csr_waddr_i, csr_wdata_i, llbit_we_i, llbit_wdata_i,
           excep_en_i, excep_ecode_i, excep_esubcode_i, excep_pc_i, excep_badv_we_i,
           excep_badv_wdata_i, ertn_en_i, hw_int_i, ipi_i,
    output csr_rdata_o, cpu_level_o, interrupt_o, eentry_o, era_o, llbit_o
  );

  modport master (
    output csr_raddr_i, csr_we_i, csr_waddr_i, csr_wdata_i, llbit_we_i, llbit_wdata_i,
           excep_en_i, excep_ecode_i, excep_esubcode_i, excep_pc_i, excep_badv_we_i,
           excep_badv_wdata_i, ertn_en_i, hw_int_i, ipi_i,
    input  csr_rdata_o, cpu_level_o, interrupt_o, eentry_o, era_o, llbit_o
  );
endinterface

// File: rtl/csr_unit_timer.sv
// Constant-frequency timer: TVAL down-counter with load, optional periodic reload and TI pulse.
module csr_unit_timer #(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [TIMER_W-3:0] i_load_val,
  input  logic               i_en,
  input  logic               i_periodic,
  input  logic [TIMER_W-3:0] i_init_val,
  output logic [TIMER_W-1:0] o_tval,
  output logic               o_ti_set
);

  logic [TIMER_W-1:0] r_tval;
  logic [TIMER_W-1:0] w_tval_nxt;
  logic               w_ti_set;

  // The TI pulse fires only on the 1->0 step, so a non-periodic timer parked at 0 stays quiet.
  always_comb begin
    w_tval_nxt = r_tval;
    w_ti_set   = 1'b0;
    if (i_load) begin
      w_tval_nxt = {i_load_val, 2'b00};
    end else if (i_en) begin
      if (r_tval != '0) begin
        w_tval_nxt = r_tval - TIMER_W'(1);
        w_ti_set   = (r_tval == TIMER_W'(1));
      end else if (i_periodic) begin
        w_tval_nxt = {i_init_val, 2'b00};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tval <= '0;
    end else begin
      r_tval <= w_tval_nxt;
    end
  end

  assign o_tval   = r_tval;
  assign o_ti_set = w_ti_set;

endmodule

// File: rtl/csr_unit.sv
// Architectural CSR file: software writes, exception entry / ERTN transitions, LLBit and timer.
module csr_unit #(
  parameter int unsigned TIMER_W = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  csr_unit_if.slave bus
);
  import csr_unit_pkg::*;

  logic [31:0] r_crmd, r_prmd, r_ecfg, r_estat, r_era, r_badv, r_eentry, r_tid, r_tcfg;
  logic [31:0] w_crmd_nxt, w_prmd_nxt, w_ecfg_nxt, w_estat_nxt, w_era_nxt, w_badv_nxt;
  logic [31:0] w_eentry_nxt, w_tid_nxt, w_tcfg_nxt;
  logic [31:0] r_save [4];
  logic [31:0] w_save_nxt [4];
  logic        r_llbit, r_klo, w_llbit_nxt, w_klo_nxt;

  logic w_we_crmd, w_we_prmd, w_we_ecfg, w_we_estat, w_we_era, w_we_badv, w_we_eentry;
  logic w_we_save, w_we_tid, w_we_tcfg, w_we_ticlr, w_we_llbctl;
  logic w_excep, w_ertn;

  logic [TIMER_W-1:0] w_tval;
  logic               w_ti_set;
  logic [31:0]        w_rdata;

  assign w_we_crmd   = bus.csr_we_i && (bus.csr_waddr_i == CsrCrmd);
  assign w_we_prmd   = bus.csr_we_i && (bus.csr_waddr_i == CsrPrmd);
  assign w_we_ecfg   = bus.csr_we_i && (bus.csr_waddr_i == CsrEcfg);
  assign w_we_estat  = bus.csr_we_i && (bus.csr_waddr_i == CsrEstat);
  assign w_we_era    = bus.csr_we_i && (bus.csr_waddr_i == CsrEra);
  assign w_we_badv   = bus.csr_we_i && (bus.csr_waddr_i == CsrBadv);
  assign w_we_eentry = bus.csr_we_i && (bus.csr_waddr_i == CsrEentry);
  assign w_we_save   = bus.csr_we_i && (bus.csr_waddr_i[13:2] == CsrSave0[13:2]);
  assign w_we_tid    = bus.csr_we_i && (bus.csr_waddr_i == CsrTid);
  assign w_we_tcfg   = bus.csr_we_i && (bus.csr_waddr_i == CsrTcfg);
  assign w_we_ticlr  = bus.csr_we_i && (bus.csr_waddr_i == CsrTiclr);
  assign w_we_llbctl = bus.csr_we_i && (bus.csr_waddr_i == CsrLlbctl);

  // Exception entry outranks ERTN, which outranks software writes to the same field.
  assign w_excep = bus.excep_en_i;
  assign w_ertn  = bus.ertn_en_i && !bus.excep_en_i;

  csr_unit_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_we_tcfg),
    .i_load_val (bus.csr_wdata_i[TIMER_W-1:2]),
    .i_en       (r_tcfg[TcfgEnBit]),
    .i_periodic (r_tcfg[TcfgPerBit]),
    .i_init_val (r_tcfg[TIMER_W-1:2]),
    .o_tval     (w_tval),
    .o_ti_set   (w_ti_set)
  );

  always_comb begin
    w_crmd_nxt = w_we_crmd ? wmerge(r_crmd, bus.csr_wdata_i, CrmdWmask) : r_crmd;
    w_prmd_nxt = w_we_prmd ? wmerge(r_prmd, bus.csr_wdata_i, PrmdWmask) : r_prmd;
    if (w_excep) begin
      w_crmd_nxt[CrmdIeBit:0] = '0;
      w_prmd_nxt[CrmdIeBit:0] = r_crmd[CrmdIeBit:0];
    end else if (w_ertn) begin
      w_crmd_nxt[CrmdIeBit:0] = r_prmd[CrmdIeBit:0];
    end

    w_ecfg_nxt   = w_we_ecfg ? wmerge(r_ecfg, bus.csr_wdata_i, EcfgWmask) : r_ecfg;
    w_eentry_nxt = w_we_eentry ? wmerge(r_eentry, bus.csr_wdata_i, EentryWmask) : r_eentry;
    w_tid_nxt    = w_we_tid ? bus.csr_wdata_i : r_tid;
    w_tcfg_nxt   = w_we_tcfg ? bus.csr_wdata_i : r_tcfg;

    w_era_nxt = w_we_era ? bus.csr_wdata_i : r_era;
    if (w_excep) w_era_nxt = bus.excep_pc_i;
    w_badv_nxt = w_we_badv ? bus.csr_wdata_i : r_badv;
    if (w_excep && bus.excep_badv_we_i) w_badv_nxt = bus.excep_badv_wdata_i;

    w_estat_nxt = w_we_estat ? wmerge(r_estat, bus.csr_wdata_i, EstatWmask) : r_estat;
    w_estat_nxt[EstatHwLsb +: 8] = bus.hw_int_i;
    w_estat_nxt[EstatIpiBit]     = bus.ipi_i;
    if (w_we_ticlr && bus.csr_wdata_i[0]) w_estat_nxt[EstatTiBit] = 1'b0;
    if (w_ti_set) w_estat_nxt[EstatTiBit] = 1'b1;
    if (w_excep) begin
      w_estat_nxt[EstatEcodeLsb +: EcodeW]   = bus.excep_ecode_i;
      w_estat_nxt[EstatEsubLsb +: EsubcodeW] = bus.excep_esubcode_i;
    end

    for (int i = 0; i < 4; i++) begin
      w_save_nxt[i] = (w_we_save && (bus.csr_waddr_i[1:0] == 2'(i))) ? bus.csr_wdata_i
                                                                       : r_save[i];
    end

    w_llbit_nxt = bus.llbit_we_i ? bus.llbit_wdata_i : r_llbit;
    if (w_we_llbctl && bus.csr_wdata_i[LlbWcllbBit]) w_llbit_nxt = 1'b0;
    w_klo_nxt = w_we_llbctl ? bus.csr_wdata_i[LlbKloBit] : r_klo;
    // KLO lets exactly one ERTN pass without dropping the reservation.
    if (w_ertn) begin
      if (r_klo) w_klo_nxt = 1'b0;
      else       w_llbit_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crmd   <= CrmdRst;
      r_prmd   <= '0;
      r_ecfg   <= '0;
      r_estat  <= '0;
      r_era    <= '0;
      r_badv   <= '0;
      r_eentry <= '0;
      r_tid    <= '0;
      r_tcfg   <= '0;
      r_llbit  <= 1'b0;
      r_klo    <= 1'b0;
      for (int i = 0; i < 4; i++) r_save[i] <= '0;
    end else begin
      r_crmd   <= w_crmd_nxt;
      r_prmd   <= w_prmd_nxt;
      r_ecfg   <= w_ecfg_nxt;
      r_estat  <= w_estat_nxt;
      r_era    <= w_era_nxt;
      r_badv   <= w_badv_nxt;
      r_eentry <= w_eentry_nxt;
      r_tid    <= w_tid_nxt;
      r_tcfg   <= w_tcfg_nxt;
      r_llbit  <= w_llbit_nxt;
      r_klo    <= w_klo_nxt;
      for (int i = 0; i < 4; i++) r_save[i] <= w_save_nxt[i];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.csr_raddr_i)
      CsrCrmd:   w_rdata = r_crmd;
      CsrPrmd:   w_rdata = r_prmd;
      CsrEcfg:   w_rdata = r_ecfg;
      CsrEstat:  w_rdata = r_estat;
      CsrEra:    w_rdata = r_era;
      CsrBadv:   w_rdata = r_badv;
      CsrEentry: w_rdata = r_eentry;
      CsrSave0:  w_rdata = r_save[0];
      CsrSave1:  w_rdata = r_save[1];
      CsrSave2:  w_rdata = r_save[2];
      CsrSave3:  w_rdata = r_save[3];
      CsrTid:    w_rdata = r_tid;
      CsrTcfg:   w_rdata = r_tcfg;
      CsrTval:   w_rdata = 32'(w_tval);
      CsrLlbctl: begin
        w_rdata[LlbKloBit] = r_klo;
        w_rdata[0]         = r_llbit;
      end
      default:   w_rdata = '0;
    endcase
  end

  assign bus.csr_rdata_o = w_rdata;
  assign bus.cpu_level_o = r_crmd[1:0];
  assign bus.interrupt_o = r_crmd[CrmdIeBit] && (|(r_estat[LieW-1:0] & r_ecfg[LieW-1:0]));
  assign bus.eentry_o    = r_eentry;
  assign bus.era_o       = r_era;
  assign bus.llbit_o     = r_llbit;

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: directed scenarios plus random traffic against a field-level model.
module tb_csr_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_unit_if bus_if ();

  csr_unit #(
    .TIMER_W (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic [13:0] raddr;
    logic        we;
    logic [13:0] waddr;
    logic [31:0] wdata;
    logic        llbit_we;
    logic        llbit_wdata;
    logic        excep;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] pc;
    logic        badv_we;
    logic [31:0] badv;
    logic        ertn;
    logic [7:0]  hw;
    logic        ipi;
  } stim_t;

  typedef struct packed {
    logic [13:0] raddr;
    logic [31:0] rdata;
    logic [1:0]  plv;
    logic        intr;
    logic        llbit;
    logic [31:0] era;
    logic [31:0] eentry;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: architectural fields by name.
  logic [1:0]  m_plv, m_pplv, m_is_sw;
  logic        m_ie, m_pie, m_ipi, m_ti, m_llbit, m_klo;
  logic [5:0]  m_crmd_hi, m_ecode;
  logic [12:0] m_lie;
  logic [7:0]  m_hw;
  logic [8:0]  m_esub;
  logic [31:0] m_era, m_badv, m_eentry, m_tid, m_tcfg, m_tval;
  logic [31:0] m_save [4];

  function automatic void model_reset();
    m_plv = 0; m_ie = 0; m_crmd_hi = 6'b000001;
    m_pplv = 0; m_pie = 0; m_lie = 0; m_is_sw = 0; m_hw = 0; m_ipi = 0; m_ti = 0;
    m_ecode = 0; m_esub = 0; m_era = 0; m_badv = 0; m_eentry = 0; m_tid = 0;
    m_tcfg = 0; m_tval = 0; m_llbit = 0; m_klo = 0;
    for (int i = 0; i < 4; i++) m_save[i] = 0;
  endfunction

  function automatic logic [12:0] m_is();
    return {m_ipi, m_ti, 1'b0, m_hw, m_is_sw};
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] a);
    case (a)
      14'h000: return {23'b0, m_crmd_hi, m_ie, m_plv};
      14'h001: return {29'b0, m_pie, m_pplv};
      14'h004: return {19'b0, m_lie};
      14'h005: return {1'b0, m_esub, m_ecode, 3'b0, m_is()};
      14'h006: return m_era;
      14'h007: return m_badv;
      14'h00C: return m_eentry;
      14'h030: return m_save[0];
      14'h031: return m_save[1];
      14'h032: return m_save[2];
      14'h033: return m_save[3];
      14'h040: return m_tid;
      14'h041: return m_tcfg;
      14'h042: return m_tval;
      14'h060: return {29'b0, m_klo, 1'b0, m_llbit};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_update(input stim_t s);
    logic [1:0]  o_plv, o_pplv;
    logic        o_ie, o_pie, o_klo, ticlr, wcllb, ti_set, tload;
    logic [31:0] o_tcfg, o_tval;
    o_plv = m_plv; o_ie = m_ie; o_pplv = m_pplv; o_pie = m_pie; o_klo = m_klo;
    o_tcfg = m_tcfg; o_tval = m_tval;
    ticlr = 0; wcllb = 0; ti_set = 0; tload = 0;
    if (s.we) begin
      case (s.waddr)
        14'h000: begin m_plv = s.wdata[1:0]; m_ie = s.wdata[2]; m_crmd_hi = s.wdata[8:3]; end
        14'h001: begin m_pplv = s.wdata[1:0]; m_pie = s.wdata[2]; end
        14'h004: m_lie = s.wdata[12:0] & 13'h1BFF;
        14'h005: m_is_sw = s.wdata[1:0];
        14'h006: m_era = s.wdata;
        14'h007: m_badv = s.wdata;
        14'h00C: m_eentry = {s.wdata[31:6], 6'b0};
        14'h030, 14'h031, 14'h032, 14'h033: m_save[s.waddr[1:0]] = s.wdata;
        14'h040: m_tid = s.wdata;
        14'h041: begin m_tcfg = s.wdata; tload = 1; end
        14'h044: ticlr = s.wdata[0];
        14'h060: begin m_klo = s.wdata[2]; wcllb = s.wdata[1]; end
        default: ;
      endcase
    end
    if (s.llbit_we) m_llbit = s.llbit_wdata;
    if (wcllb) m_llbit = 0;
    m_hw = s.hw;
    m_ipi = s.ipi;
    if (tload) begin
      m_tval = s.wdata & 32'hFFFF_FFFC;
    end else if (o_tcfg[0]) begin
      if (o_tval > 0) begin
        m_tval = o_tval - 1;
        ti_set = (m_tval == 0);
      end else if (o_tcfg[1]) begin
        m_tval = o_tcfg & 32'hFFFF_FFFC;
      end
    end
    if (ticlr) m_ti = 0;
    if (ti_set) m_ti = 1;
    if (s.excep) begin
      m_pplv = o_plv; m_pie = o_ie; m_plv = 0; m_ie = 0;
      m_ecode = s.ecode; m_esub = s.esub; m_era = s.pc;
      if (s.badv_we) m_badv = s.badv;
    end else if (s.ertn) begin
      m_plv = o_pplv; m_ie = o_pie;
      if (o_klo) m_klo = 0;
      else m_llbit = 0;
    end
  endfunction

  task automatic drive(input stim_t s);
    bus_if.csr_raddr_i        = s.raddr;
    bus_if.csr_we_i           = s.we;
    bus_if.csr_waddr_i        = s.waddr;
    bus_if.csr_wdata_i        = s.wdata;
    bus_if.llbit_we_i         = s.llbit_we;
    bus_if.llbit_wdata_i      = s.llbit_wdata;
    bus_if.excep_en_i         = s.excep;
    bus_if.excep_ecode_i      = s.ecode;
    bus_if.excep_esubcode_i   = s.esub;
    bus_if.excep_pc_i         = s.pc;
    bus_if.excep_badv_we_i    = s.badv_we;
    bus_if.excep_badv_wdata_i = s.badv;
    bus_if.ertn_en_i          = s.ertn;
    bus_if.hw_int_i           = s.hw;
    bus_if.ipi_i              = s.ipi;
  endtask

  function automatic stim_t nop(input logic [13:0] ra);
    stim_t s;
    s = '0;
    s.raddr = ra;
    return s;
  endfunction

  function automatic stim_t wr(input logic [13:0] wa, input logic [31:0] wd,
                               input logic [13:0] ra);
    stim_t s;
    s = nop(ra);
    s.we = 1; s.waddr = wa; s.wdata = wd;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    drive(s);
    e.raddr = s.raddr;
    e.rdata = m_read(s.raddr);
    e.plv = m_plv;
    e.intr = m_ie && (|(m_is() & m_lie));
    e.llbit = m_llbit;
    e.era = m_era;
    e.eentry = m_eentry;
    sb_q.push_back(e);
    model_update(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    drive(nop(14'h0));
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic stim_t rand_stim();
    logic [13:0] addrs [17];
    stim_t s;
    addrs = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007, 14'h00C, 14'h030,
              14'h031, 14'h032, 14'h033, 14'h040, 14'h041, 14'h042, 14'h044, 14'h060, 14'h002};
    s = '0;
    s.raddr = addrs[$urandom_range(0, 16)];
    s.we = ($urandom_range(0, 2) == 0);
    s.waddr = addrs[$urandom_range(0, 16)];
    s.wdata = $urandom;
    if (s.waddr == 14'h041) begin
      if ($urandom_range(0, 3) != 0) s.we = 0;
      s.wdata = ($urandom_range(0, 6) << 2) | $urandom_range(0, 3);
    end
    s.llbit_we = ($urandom_range(0, 15) == 0);
    s.llbit_wdata = $urandom_range(0, 1);
    s.excep = ($urandom_range(0, 19) == 0);
    s.ecode = 6'($urandom);
    s.esub = 9'($urandom);
    s.pc = $urandom;
    s.badv_we = $urandom_range(0, 1);
    s.badv = $urandom;
    s.ertn = ($urandom_range(0, 19) == 0);
    s.hw = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
    s.ipi = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  task automatic chk(input string name, input logic [13:0] ra, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s raddr=0x%0h actual=0x%0h required=0x%0h", name, ra, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rdata", e.raddr, bus_if.csr_rdata_o, e.rdata);
        chk("cpu_level", e.raddr, 32'(bus_if.cpu_level_o), 32'(e.plv));
        chk("interrupt", e.raddr, 32'(bus_if.interrupt_o), 32'(e.intr));
        chk("llbit", e.raddr, 32'(bus_if.llbit_o), 32'(e.llbit));
        chk("era", e.raddr, bus_if.era_o, e.era);
        chk("eentry", e.raddr, bus_if.eentry_o, e.eentry);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    drive(nop(14'h0));
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    step(nop(14'h000));
    step(nop(14'h042));

    // Exception entry then return.
    step(wr(14'h000, 32'h7, 14'h000));
    s = nop(14'h000); s.excep = 1; s.ecode = 6'hB; s.pc = 32'h1C00_0100; step(s);
    step(nop(14'h000)); step(nop(14'h001)); step(nop(14'h006)); step(nop(14'h005));
    s = nop(14'h000); s.ertn = 1; step(s);
    step(nop(14'h000));

    // Periodic timer with interrupt enabled.
    step(wr(14'h004, 32'h800, 14'h004));
    step(wr(14'h000, 32'h4, 14'h000));
    step(wr(14'h041, 32'h13, 14'h041));
    for (int i = 0; i < 40; i++) step(nop((i % 2 == 0) ? 14'h042 : 14'h005));
    step(wr(14'h044, 32'h1, 14'h005));
    step(nop(14'h005));

    // One-shot timer.
    step(wr(14'h041, 32'h9, 14'h042));
    step(wr(14'h044, 32'h1, 14'h005));
    for (int i = 0; i < 30; i++) step(nop((i % 2 == 0) ? 14'h042 : 14'h005));

    // Reset in the middle of a count.
    step(wr(14'h041, 32'h13, 14'h042));
    repeat (5) step(nop(14'h042));
    do_reset();
    step(nop(14'h042)); step(nop(14'h000)); step(nop(14'h041)); step(nop(14'h005));

    // LLBit retained across one ERTN by KLO.
    s = nop(14'h060); s.llbit_we = 1; s.llbit_wdata = 1; step(s);
    step(wr(14'h060, 32'h4, 14'h060));
    s = nop(14'h060); s.ertn = 1; step(s);
    step(nop(14'h060));
    s = nop(14'h060); s.ertn = 1; step(s);
    step(nop(14'h060));

    // Exception beats a same-cycle CRMD write.
    step(wr(14'h000, 32'h7, 14'h000));
    s = wr(14'h000, 32'h3, 14'h000); s.excep = 1; s.pc = 32'h1C00_0200; step(s);
    step(nop(14'h000)); step(nop(14'h001));

    for (int i = 0; i < 3000; i++) begin
      step(rand_stim());
      if (i == 1500) begin
        s = rand_stim(); s.excep = 1; step(s);
        do_reset();
        step(nop(14'h000)); step(nop(14'h005));
      end
    end

    @(negedge clk);
    #5;
    chk("queue_drain", 14'h0, 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
